// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: reset PC, the canonical NOP and the queue entry layout.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
module fetch_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_C);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue is only legal alongside a pop; upstream credit keeps it so.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && o_full && !i_pop && !i_flush));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited imem requests,
// response queueing and redirect with discard of stale in-flight responses.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        instr_valid
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic          r_started;

  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;
  logic [CW-1:0] w_q_count;
  logic          w_q_empty;
  logic          w_q_full_unused;
  logic [CW-1:0] w_used;
  logic [CW-1:0] w_out_next;
  logic          w_fire;
  logic          w_drop_now;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_target;
  logic          w_unused_pc_lsb;

  // r_started keeps the request channel quiet for the first cycle out of reset.
  assign w_used         = r_outstanding + w_q_count;
  assign imem_req_valid = r_started && !redirect_valid && (w_used < DEPTH_C);
  assign imem_req_addr  = r_fetch_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign w_drop_now  = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_push      = imem_rsp_valid && !w_drop_now && !redirect_valid;
  assign w_pop       = !w_q_empty && !stall && !redirect_valid;
  assign w_out_next  = r_outstanding + CW'(w_fire) - CW'(imem_rsp_valid);
  assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};

  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb   = ^redirect_pc[1:0];

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_q_count),
    .o_empty (w_q_empty),
    .o_full  (w_q_full_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_started     <= 1'b0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= w_redirect_target;
        r_rsp_pc   <= w_redirect_target;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_fire)     r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
        if (w_drop_now) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  assign instr_valid = !w_q_empty;
  assign pc          = w_q_empty ? r_rsp_pc  : w_head.pc;
  assign instruction = w_q_empty ? NOP_INSTR : w_head.instr;
endmodule
